// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - parametrised UART frame transmitter with programmable bit period
//
// Frame: start bit, DATA_WIDTH data bits LSB first, optional parity, one or two stop bits.
// Optional feature macro: UART_TX_PARITY_EN (parity generator and PARITY state).
//
// Ports:
//   clk         single clock
//   rst         synchronous active-low reset
//   p_data      word to send
//   data_valid  request to send p_data (ignored while busy)
//   par_en      1 = insert parity bit (only with UART_TX_PARITY_EN)
//   par_typ     0 = even, 1 = odd parity (only with UART_TX_PARITY_EN)
//   stop2       1 = two stop bits
//   prescale    bit period minus one, in clocks
//   tx_out      registered serial line, idle high
//   busy        frame in progress
//   done        one-cycle pulse in the first idle cycle after a frame

module uart_tx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stop2,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  done
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP1, STOP2} state_t;
`endif

    state_t                  state_q, state_d;
    logic [PRESCALE_W-1:0]   cnt_q, cnt_d, cnt_dec, prescale_q;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic                    stop2_q;
    logic                    tx_d;
    logic                    done_d;
    logic                    bit_end;
    logic                    accept;

`ifdef UART_TX_PARITY_EN
    logic                    par_en_q;
    logic                    par_bit_q;
`else
    logic                    unused_par;
    assign unused_par = par_en ^ par_typ;
`endif

    assign bit_end = (cnt_q == '0);
    assign cnt_dec = cnt_q - PRESCALE_W'(1);
    assign accept  = (state_q == IDLE) && data_valid;
    assign busy    = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;

        // Every non-idle state shares the same bit timer: reload at the end of a bit.
        if (state_q != IDLE) begin
            cnt_d = bit_end ? prescale_q : cnt_dec;
        end

        case (state_q)
            IDLE: begin
                if (data_valid) begin
                    state_d = START;
                    cnt_d   = prescale;
                    idx_d   = '0;
                    shreg_d = p_data;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = par_en_q ? PARITY : STOP1;
`else
                        state_d = STOP1;
`endif
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP1;
            end
`endif
            STOP1: begin
                if (bit_end) begin
                    state_d = stop2_q ? STOP2 : IDLE;
                    done_d  = ~stop2_q;
                end
            end
            STOP2: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // tx_out is registered, so its level follows the state being entered.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_bit_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
            prescale_q <= '0;
            stop2_q    <= 1'b0;
            tx_out     <= 1'b1;
            done       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_out  <= tx_d;
            done    <= done_d;
            if (accept) begin
                prescale_q <= prescale;
                stop2_q    <= stop2;
`ifdef UART_TX_PARITY_EN
                par_en_q   <= par_en;
                // Parity is fixed at accept time; the shift register is consumed later.
                par_bit_q  <= (^p_data) ^ par_typ;
`endif
            end
        end
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter that serialises one `DATA_WIDTH`-bit word per frame: start bit, data LSB first, optional parity, then one or two stop bits. Each bit lasts a run-time programmable number of clocks. The block replaces the fixed 8-bit, one-bit-per-clock transmitter path and sits between the host-side parallel interface and the serial pin.

## Interface
Parameters:
- `DATA_WIDTH`, 8: data bits per frame; legal range 5–9.
- `PRESCALE_W`, 16: width of `prescale`.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-low reset.
- `p_data`  in  DATA_WIDTH: word to send.
- `data_valid`  in  1: request to send `p_data`.
- `par_en`  in  1: 1 = parity bit inserted.
- `par_typ`  in  1: 0 = even parity, 1 = odd parity.
- `stop2`  in  1: 1 = two stop bits, 0 = one stop bit.
- `prescale`  in  PRESCALE_W: bit period minus one, in clocks.
- `tx_out`  out  1: serial line, registered, idle high.
- `busy`  out  1: frame in progress; the block accepts no word while high.
- `done`  out  1: one-cycle pulse after a frame completes.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- **IDLE**
  - Outputs: `tx_out`=1, `busy`=0.
  - If `data_valid`=1, the block latches `p_data`, `par_en`, `par_typ`, `stop2` and `prescale`, then moves to START.
- **Bit timing**
  - A bit counter reloads to the latched `prescale` on entry to each bit.
  - It decrements each clock. When it reaches 0, the FSM advances to the next bit.
  - Each bit therefore lasts `prescale`+1 clocks. `prescale`=0 gives 1 clock per bit.
- **DATA**
  - Sends a shift-register copy of the word, LSB first.
  - An index counter of width clog2(`DATA_WIDTH`) ends this state after `DATA_WIDTH` bits.
- **Transitions**
  - DATA → PARITY if latched `par_en`=1, otherwise → STOP1.
  - STOP1 → STOP2 if latched `stop2`=1, otherwise → IDLE.
  - STOP2 → IDLE.
- **Parity bit**
  - Even: XOR-reduce of the latched word.
  - Odd: inverse of that XOR-reduce.
- **Line levels:** `tx_out`=0 in START and 1 in STOP1 and STOP2.
- **Ignored inputs**
  - `data_valid` while `busy`=1 is ignored. The word is dropped, not queued.
  - Changes on any input during a frame do not affect that frame.
- **Frame length** = (`prescale`+1) × (1 + `DATA_WIDTH` + P + S) clocks, where P = `par_en` (0 or 1) and S = 1 + `stop2`.

## Timing
- **Reset values:** state IDLE, `tx_out`=1, `busy`=0, `done`=0, all counters 0.
- **Reset mid-frame:** the frame aborts. `tx_out`=1 on the cycle after reset is sampled low, and `done` is not pulsed.
- **Start latency:** accepted at edge N. The first start-bit cycle (`tx_out`=0, `busy`=1) is cycle N+1.
- `busy` is high from the first start-bit cycle through the last stop-bit cycle inclusive.
- `done`=1 for exactly the first IDLE cycle after STOP1 or STOP2 completes.
- **Back-to-back frames**
  - If `data_valid` is high in the `done` cycle, the next word is accepted that cycle.
  - Consecutive frames are therefore separated by exactly one idle-high clock.

## Configuration
- **Macro `UART_TX_PARITY_EN`.**
- **Defined:** the parity generator and the PARITY state are compiled in, and `par_en`/`par_typ` behave as above.
- **Undefined:**
  - The parity logic and the PARITY state are removed.
  - `par_en` and `par_typ` are ignored, so frames never carry a parity bit.
  - DATA → STOP1 always.
  - The ports remain present.

## Test plan
- **Basic frame with parity:** `DATA_WIDTH`=8, macro defined, `prescale`=3, `p_data`=0xA5, `par_en`=1, `par_typ`=0, `stop2`=0, one-cycle `data_valid`.
  - `tx_out` must be 0, 1,0,1,0,0,1,0,1, 0, 1, with each bit held 4 clocks.
  - `busy` high for 44 clocks, then `done` pulses once.
- **Odd parity, two stop bits, minimum prescale:** `prescale`=0, `p_data`=0x07, `par_en`=1, `par_typ`=1, `stop2`=1.
  - `tx_out` must be 0,1,1,1,0,0,0,0,0,0,1,1, one clock each.
  - `busy` high for 12 clocks.
- **Request while busy:** during the first test, pulse `data_valid` with `p_data`=0x3C at clock 20 of the frame.
  - The frame is unchanged and 0x3C is never transmitted.
- **Back-to-back frames:** hold `data_valid`=1 with 0x55 then 0xAA, `prescale`=1, `par_en`=0, `stop2`=0.
  - Two 20-clock frames separated by exactly one idle-high clock.
  - `done` pulses in that idle clock.
- **Reset mid-frame:** drive `rst`=0 in the DATA state.
  - Next cycle: `tx_out`=1, `busy`=0, `done`=0.
  - After reset release, a fresh 0xA5 frame matches the first test exactly.
- **Macro undefined:** `par_en`=1, `p_data`=0xFF, `prescale`=0.
  - Frame is 10 clocks: 0, eight 1s, 1.
  - No parity bit.
